// File: rtl/mini_src_ctrl_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit.
// Holds the opcode map, ALU operation codes, the timing-step state
// encoding and the instruction classes produced by the opcode decoder.
package mini_src_ctrl_pkg;

    localparam int OP_W  = 5;
    localparam int ALU_W = 5;

    // Opcodes as found in IR[31:27].
    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

    // ALU operation codes driven on alu_control.
    localparam logic [ALU_W-1:0] ALU_ADD = 5'b00001;
    localparam logic [ALU_W-1:0] ALU_SUB = 5'b00010;
    localparam logic [ALU_W-1:0] ALU_AND = 5'b00011;
    localparam logic [ALU_W-1:0] ALU_OR  = 5'b00100;

    // Timing steps T0..T7 occupy the contiguous codes 0111..1110.
    typedef enum logic [3:0] {
        S_RESET = 4'b0000,
        S_PAUSE = 4'b0001,
        S_T0    = 4'b0111,
        S_T1    = 4'b1000,
        S_T2    = 4'b1001,
        S_T3    = 4'b1010,
        S_T4    = 4'b1011,
        S_T5    = 4'b1100,
        S_T6    = 4'b1101,
        S_T7    = 4'b1110,
        S_HALT  = 4'b1111
    } state_e;

    typedef enum logic [2:0] {
        CL_RR,    // register-register ALU
        CL_IMM,   // immediate ALU
        CL_LDI,
        CL_LD,
        CL_ST,
        CL_NOP,
        CL_HALT,
        CL_ILL    // unsupported opcode
    } instr_class_e;

endpackage

// File: rtl/mini_src_op_decode.sv
// Combinational opcode decoder for the Mini SRC control unit.
// Ports:
//   op       in  : IR[31:27] opcode
//   iclass   out : instruction class steering the execute steps
//   alu_code out : ALU operation used in T4 (ADD for ldi/ld/st address math)
module mini_src_op_decode
    import mini_src_ctrl_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int ALUW = 5
) (
    input  logic [OPW-1:0]  op,
    output instr_class_e    iclass,
    output logic [ALUW-1:0] alu_code
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves a value unassigned and infers a latch.
    always_comb begin
        iclass   = CL_ILL;
        alu_code = '0;
        case (op)
            OP_ADD:  begin iclass = CL_RR;   alu_code = ALU_ADD; end
            OP_SUB:  begin iclass = CL_RR;   alu_code = ALU_SUB; end
            OP_AND:  begin iclass = CL_RR;   alu_code = ALU_AND; end
            OP_OR:   begin iclass = CL_RR;   alu_code = ALU_OR;  end
            OP_ADDI: begin iclass = CL_IMM;  alu_code = ALU_ADD; end
            OP_ANDI: begin iclass = CL_IMM;  alu_code = ALU_AND; end
            OP_ORI:  begin iclass = CL_IMM;  alu_code = ALU_OR;  end
            OP_LDI:  begin iclass = CL_LDI;  alu_code = ALU_ADD; end
            OP_LD:   begin iclass = CL_LD;   alu_code = ALU_ADD; end
            OP_ST:   begin iclass = CL_ST;   alu_code = ALU_ADD; end
            OP_NOP:  iclass = CL_NOP;
            OP_HALT: iclass = CL_HALT;
            default: iclass = CL_ILL;
        endcase
    end

endmodule

// File: rtl/mini_src_control_unit.sv
// Hardwired control sequencer for the Mini SRC datapath.
// A timing-step FSM (RESET, T0..T7, PAUSE, HALT) plus the IR opcode drive
// all datapath controls as Moore outputs.
// Ports:
//   clk, clr (sync active-low reset), ir_op (IR[31:27]), mem_rdy (memory
//   handshake), stop (pause request at instruction boundary)
//   Pout..IRen        : fetch / memory controls
//   Yen..BAout        : ALU path controls
//   Gra..Rout         : register select / enable
//   alu_control       : ALU operation
//   run               : high in T0..T7
//   illegal           : T3 pulse on an unsupported opcode
module mini_src_control_unit
    import mini_src_ctrl_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int ALUW = 5
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [OPW-1:0]  ir_op,
    input  logic            mem_rdy,
    input  logic            stop,
    output logic            Pout,
    output logic            IncPC,
    output logic            MARen,
    output logic            Read,
    output logic            Write,
    output logic            MDRen,
    output logic            MDROut,
    output logic            IRen,
    output logic            Yen,
    output logic            Zen,
    output logic            Cout,
    output logic            ZLOout,
    output logic            BAout,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic [ALUW-1:0] alu_control,
    output logic            run,
    output logic            illegal
);

    state_e          state;
    state_e          state_next;
    state_e          entry_state;
    instr_class_e    iclass;
    logic [ALUW-1:0] alu_code;

    mini_src_op_decode #(.OPW(OPW), .ALUW(ALUW)) u_decode (
        .op       (ir_op),
        .iclass   (iclass),
        .alu_code (alu_code)
    );

    // Every instruction boundary diverts to PAUSE while stop is requested.
    assign entry_state = stop ? S_PAUSE : S_T0;

    assign run = !(state inside {S_RESET, S_PAUSE, S_HALT});

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (!clr) state <= S_RESET;
        else      state <= state_next;
    end

    always_comb begin
        state_next  = state;
        Pout        = 1'b0;
        IncPC       = 1'b0;
        MARen       = 1'b0;
        Read        = 1'b0;
        Write       = 1'b0;
        MDRen       = 1'b0;
        MDROut      = 1'b0;
        IRen        = 1'b0;
        Yen         = 1'b0;
        Zen         = 1'b0;
        Cout        = 1'b0;
        ZLOout      = 1'b0;
        BAout       = 1'b0;
        Gra         = 1'b0;
        Grb         = 1'b0;
        Grc         = 1'b0;
        Rin         = 1'b0;
        Rout        = 1'b0;
        alu_control = '0;
        illegal     = 1'b0;

        case (state)
            S_RESET: state_next = entry_state;
            S_PAUSE: if (!stop) state_next = S_T0;
            S_HALT:  state_next = S_HALT;
            S_T0: begin
                Pout = 1'b1; MARen = 1'b1; IncPC = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                Read = 1'b1; MDRen = 1'b1;
                if (mem_rdy) state_next = S_T2;
            end
            S_T2: begin
                MDROut = 1'b1; IRen = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                case (iclass)
                    CL_RR, CL_IMM: begin
                        Grb = 1'b1; Rout = 1'b1; Yen = 1'b1;
                        state_next = S_T4;
                    end
                    // BAout forces zero for R0 so ldi/ld/st form base+offset.
                    CL_LDI, CL_LD, CL_ST: begin
                        Grb = 1'b1; BAout = 1'b1; Yen = 1'b1;
                        state_next = S_T4;
                    end
                    CL_NOP:  state_next = entry_state;
                    CL_HALT: state_next = S_HALT;
                    default: begin
                        illegal    = 1'b1;
                        state_next = entry_state;
                    end
                endcase
            end
            S_T4: begin
                Zen         = 1'b1;
                alu_control = alu_code;
                if (iclass == CL_RR) begin
                    Grc = 1'b1; Rout = 1'b1;
                end else begin
                    Cout = 1'b1;
                end
                state_next = S_T5;
            end
            S_T5: begin
                ZLOout = 1'b1;
                if (iclass inside {CL_LD, CL_ST}) begin
                    MARen      = 1'b1;
                    state_next = S_T6;
                end else begin
                    Gra = 1'b1; Rin = 1'b1;
                    state_next = entry_state;
                end
            end
            S_T6: begin
                MDRen = 1'b1;
                if (iclass == CL_LD) begin
                    Read = 1'b1;
                    if (mem_rdy) state_next = S_T7;
                end else begin
                    // Read stays low so the MDR captures the bus (Ra value).
                    Gra = 1'b1; Rout = 1'b1;
                    state_next = S_T7;
                end
            end
            S_T7: begin
                if (iclass == CL_LD) begin
                    MDROut = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    state_next = entry_state;
                end else begin
                    Write = 1'b1;
                    if (mem_rdy) state_next = entry_state;
                end
            end
            default: state_next = S_RESET;
        endcase
    end

endmodule

// File: doc/mini_src_control_unit.md
Name: mini_src_control_unit

Overview:
- Hardwired control sequencer for the Mini SRC datapath.
- Drives every datapath enable, output-select and ALU-op line from a timing-step state machine and the IR opcode. It replaces hand-written per-instruction stimulus sequences.
- Sits beside the datapath and connects to it one-to-one by signal name; it also handshakes with memory through mem_rdy.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- ALUW, 5, alu_control width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  reset, synchronous, active-low.
- ir_op  in  OPW  IR[31:27] from datapath IR register.
- mem_rdy  in  1  memory completes current Read/Write this cycle.
- stop  in  1  pause request, honoured only at instruction boundary.
- Pout, IncPC, MARen, Read, Write, MDRen, MDROut, IRen  out  1  fetch/memory controls.
- Yen, Zen, Cout, ZLOout, BAout  out  1  ALU path controls.
- Gra, Grb, Grc, Rin, Rout  out  1  register select/enable, to select-and-encode logic.
- alu_control  out  ALUW  ALU operation.
- run  out  1  high while executing; low in RESET, PAUSE, HALT.
- illegal  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- States: RESET, T0–T7, PAUSE, HALT; 4-bit encoded register.
- Outputs are Moore: decoded combinationally from the state register and ir_op. Each output is stable for the whole cycle and is sampled by the datapath on the next rising edge.
- Reset: clr=0 at a rising edge forces RESET from any state, including mid-instruction and a memory wait. In RESET every output is 0, alu_control=0 and run=0. RESET goes to T0 on the first edge with clr=1.
- Fetch:
  - T0: Pout, MARen, IncPC.
  - T1: Read, MDRen. Remain in T1 while mem_rdy=0, with outputs held.
  - T2: MDROut, IRen. IR is valid from T3.
- Reg-reg ALU (add 00011, sub 00100, and 01001, or 01010):
  - T3: Grb, Rout, Yen.
  - T4: Grc, Rout, Zen, alu_control=op.
  - T5: ZLOout, Gra, Rin; then T0.
- Immediate ALU (addi 01011, andi 01100, ori 01101):
  - T3: Grb, Rout, Yen.
  - T4: Cout, Zen, alu_control=ADD/AND/OR.
  - T5: ZLOout, Gra, Rin; then T0.
- ldi 00001:
  - T3: Grb, BAout, Yen.
  - T4: Cout, Zen, ALU_ADD.
  - T5: ZLOout, Gra, Rin; then T0.
- ld 00000:
  - T3–T4 as ldi.
  - T5: ZLOout, MARen.
  - T6: Read, MDRen; wait on mem_rdy.
  - T7: MDROut, Gra, Rin; then T0.
- st 00010:
  - T3–T5 as ld.
  - T6: Gra, Rout, MDRen (Read=0, so MDR loads from bus).
  - T7: Write; wait on mem_rdy; then T0.
- nop 11001: T3 with all outputs 0, then T0.
- halt 11010: T3 goes to HALT. HALT keeps all outputs 0 and run=0, and is left only by reset.
- Any other opcode: illegal=1 for the T3 cycle only, other outputs 0, then T0.
- mem_rdy is ignored outside T1, T6(ld) and T7(st).
- Stop handling: on any transition into T0, if stop=1 the FSM goes to PAUSE instead. PAUSE keeps outputs 0 and run=0 until stop=0, then goes to T0. A stop raised mid-instruction is held off until the boundary.
- Simultaneous events: clr=0 beats stop and mem_rdy. When T5 exits and stop=1 is sampled on the same edge, PAUSE wins.
- Latency with mem_rdy=1: reg-reg/imm/ldi = 6 cycles, ld/st = 8, nop = 4.

Decomposition:
- Package mini_src_ctrl_pkg holds:
  - Opcode constants (OP_LD … OP_HALT).
  - ALU codes: ALU_ADD=00001, ALU_SUB=00010, ALU_AND=00011, ALU_OR=00100.
  - State encoding: RESET=0000, T0=0111 … T6=1101, T7=1110, PAUSE=0001, HALT=1111.
- One sub-module, mini_src_op_decode: a combinational map of ir_op to instruction class (RR, IMM, LDI, LD, ST, NOP, HALT, ILL) and ALU code.

Test Plan:
- Reset then andi R2,R3,0x25 with mem_rdy=1 → T3 Grb/Rout/Yen; T4 Cout/Zen/alu_control=00011; T5 ZLOout/Gra/Rin; back in T0 at cycle 7.
- add, with mem_rdy low for 3 cycles in T1 → Read/MDRen held 4 cycles, IRen asserted only in the cycle after mem_rdy=1.
- st, with mem_rdy delayed 2 cycles in T7 → Write held 3 cycles; T0 follows. ld → T6 Read/MDRen, T7 Gra/Rin/MDROut.
- clr=0 during the T6 memory wait of ld → next cycle all outputs 0 and run=0; T0 one cycle after clr=1.
- stop=1 asserted in T4 of ori → T5 completes, then PAUSE with run=0; stop=0 → T0 next edge.
- Opcode 11111 → illegal one-cycle pulse in T3, then T0. halt 11010 → HALT persists 20 cycles with all outputs 0.
